// File: rtl/debounce_multi.sv
// debounce_multi: N-channel button debouncer with commit-first or restart glitch policy and press/release/long pulses
module debounce_multi #(
  parameter int CHANNELS       = 4,
  parameter int DEBOUNCE_TICKS = 4096,
  parameter int LONG_TICKS     = 0,
  parameter int RESTART        = 0,
  parameter int ACTIVE_LOW     = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                tp_i,
  input  logic [CHANNELS-1:0] btn_i,
  output logic [CHANNELS-1:0] btn_o,
  output logic [CHANNELS-1:0] press_o,
  output logic [CHANNELS-1:0] release_o,
  output logic [CHANNELS-1:0] long_o
);
  localparam int CW = $clog2(DEBOUNCE_TICKS);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_TICKS - 1);
  typedef enum logic [1:0] {WAIT_LOW, CNT_HIGH, WAIT_HIGH, CNT_LOW} state_t;
  logic [CHANNELS-1:0] raw, s1_q, s2_q;
  assign raw = btn_i ^ {CHANNELS{ACTIVE_LOW != 0}};
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
    end
  end
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic btn_q, btn_d, press_q, rel_q, last;
    always_comb begin
      last = tp_i && cnt_q == CNT_MAX;
      state_d = state_q;
      cnt_d = cnt_q;
      unique case (state_q)
        WAIT_LOW: if (s2_q[c]) begin
          state_d = CNT_HIGH;
          cnt_d = '0;
        end
        WAIT_HIGH: if (!s2_q[c]) begin
          state_d = CNT_LOW;
          cnt_d = '0;
        end
        CNT_HIGH: if (RESTART != 0 && !s2_q[c]) begin
          state_d = WAIT_LOW;
          cnt_d = '0;
        end else if (last) begin
          state_d = WAIT_HIGH;
          cnt_d = '0;
        end else if (tp_i) cnt_d = cnt_q + 1'b1;
        CNT_LOW: if (RESTART != 0 && s2_q[c]) begin
          state_d = WAIT_HIGH;
          cnt_d = '0;
        end else if (last) begin
          state_d = WAIT_LOW;
          cnt_d = '0;
        end else if (tp_i) cnt_d = cnt_q + 1'b1;
      endcase
      // commit-first reports the level as soon as counting starts; restart only once the window completes
      btn_d = RESTART != 0 ? (state_d == WAIT_HIGH || state_d == CNT_LOW)
                           : (state_d == CNT_HIGH || state_d == WAIT_HIGH);
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state_q <= WAIT_LOW;
        cnt_q <= '0;
        btn_q <= 1'b0;
        press_q <= 1'b0;
        rel_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q <= cnt_d;
        btn_q <= btn_d;
        press_q <= btn_d & ~btn_q;
        rel_q <= ~btn_d & btn_q;
      end
    end
    assign btn_o[c] = btn_q;
    assign press_o[c] = press_q;
    assign release_o[c] = rel_q;
    if (LONG_TICKS > 0) begin : g_long
      localparam int HW = $clog2(LONG_TICKS + 1);
      localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_TICKS);
      logic [HW-1:0] hold_q, hold_d;
      logic long_q, long_d;
      always_comb begin
        hold_d = !btn_q ? '0 : (tp_i && hold_q != HOLD_MAX) ? hold_q + 1'b1 : hold_q;
        long_d = hold_d == HOLD_MAX && hold_q != HOLD_MAX;
      end
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          hold_q <= '0;
          long_q <= 1'b0;
        end else begin
          hold_q <= hold_d;
          long_q <= long_d;
        end
      end
      assign long_o[c] = long_q;
    end else begin : g_nolong
      assign long_o[c] = 1'b0;
    end
  end
endmodule
